// File: rtl/grey_rx6_check.sv
// Grey-count receiver: synchronises grey_in, decodes to binary and checks single +1 steps.
// Optional stall timeout is built only when GREY_RX_STALL_EN is defined.
module grey_rx6_check #(
   parameter int unsigned W            = 6,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned LOCK_STEPS   = 4,
   parameter int unsigned ERR_W        = 8,
   parameter int unsigned STALL_CYCLES = 64
) (
   input  logic             clk,
   input  logic             w_rst,
   input  logic [W-1:0]     grey_in,
   input  logic             clr_err,
   output logic [W-1:0]     bin,
   output logic             step,
   output logic             err,
   output logic [ERR_W-1:0] err_cnt,
   output logic             locked,
   output logic             stall
);

   localparam int unsigned FlushW = $clog2(SYNC_STAGES + 1);
   localparam int unsigned LockW  = $clog2(LOCK_STEPS + 1);

   typedef enum logic [1:0] {StFlush, StLocking, StLocked} state_e;

   state_e             state_q, state_d;
   logic [W-1:0]       sync_q [SYNC_STAGES];
   logic [W-1:0]       dec;
   logic [W-1:0]       delta;
   logic               is_step, is_ill;
   logic [FlushW-1:0]  flush_cnt_q, flush_cnt_d;
   logic [LockW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [W-1:0]       bin_q, bin_d;
   logic               step_q, step_d;
   logic               err_q, err_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic               locked_q;

   always_ff @(posedge clk) begin
      if (w_rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= grey_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Binary bit i is the XOR of Grey bits i..W-1.
   always_comb begin
      dec = '0;
      for (int i = 0; i < W; i++) dec[i] = ^(sync_q[SYNC_STAGES-1] >> i);
   end

   assign delta   = dec - bin_q;
   assign is_step = (delta == W'(1));
   assign is_ill  = (delta != '0) && !is_step;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      lock_cnt_d  = lock_cnt_q;
      bin_d       = bin_q;
      step_d      = 1'b0;
      err_d       = 1'b0;
      err_cnt_d   = clr_err ? '0 : err_cnt_q;
      case (state_q)
         StFlush: begin
            // Wait for the synchroniser to fill before the first load.
            if (flush_cnt_q == FlushW'(SYNC_STAGES)) begin
               bin_d      = dec;
               lock_cnt_d = '0;
               state_d    = StLocking;
            end else begin
               flush_cnt_d = flush_cnt_q + 1'b1;
            end
         end
         StLocking: begin
            bin_d = dec;
            if (is_step) begin
               step_d = 1'b1;
               if (lock_cnt_q == LockW'(LOCK_STEPS - 1)) begin
                  lock_cnt_d = '0;
                  state_d    = StLocked;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end else if (is_ill) begin
               lock_cnt_d = '0;
            end
         end
         StLocked: begin
            bin_d = dec;
            if (is_step) begin
               step_d = 1'b1;
            end else if (is_ill) begin
               err_d      = 1'b1;
               lock_cnt_d = '0;
               state_d    = StLocking;
               if (clr_err) begin
                  err_cnt_d = ERR_W'(1);
               end else if (err_cnt_q != '1) begin
                  err_cnt_d = err_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = StFlush;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         state_q     <= StFlush;
         flush_cnt_q <= '0;
         lock_cnt_q  <= '0;
         bin_q       <= '0;
         step_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
         bin_q       <= bin_d;
         step_q      <= step_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         locked_q    <= (state_d == StLocked);
      end
   end

`ifdef GREY_RX_STALL_EN
   localparam int unsigned StallW = $clog2(STALL_CYCLES + 1);

   logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
   logic              stall_q, stall_d;

   // Counter and flag both clear on a step or whenever LOCKED is left.
   always_comb begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
      if (state_d == StLocked && !step_d) begin
         stall_cnt_d = (stall_cnt_q == StallW'(STALL_CYCLES)) ? stall_cnt_q
                                                              : stall_cnt_q + 1'b1;
         stall_d     = stall_q || (stall_cnt_d == StallW'(STALL_CYCLES));
      end
   end

   always_ff @(posedge clk) begin
      if (w_rst) begin
         stall_cnt_q <= '0;
         stall_q     <= 1'b0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         stall_q     <= stall_d;
      end
   end

   assign stall = stall_q;
`else
   assign stall = 1'b0;
`endif

   assign bin     = bin_q;
   assign step    = step_q;
   assign err     = err_q;
   assign err_cnt = err_cnt_q;
   assign locked  = locked_q;

endmodule

// File: tb/tb_grey_rx6_check.sv
// Directed bench for grey_rx6_check (ERR_W=2 so saturation is reachable quickly).
module tb_grey_rx6_check;

   localparam int unsigned W     = 6;
   localparam int unsigned ERR_W = 2;

   logic             clk = 1'b0;
   logic             w_rst;
   logic [W-1:0]     grey_in;
   logic             clr_err;
   logic [W-1:0]     bin;
   logic             step;
   logic             err;
   logic [ERR_W-1:0] err_cnt;
   logic             locked;
   logic             stall;

   always #5 clk = ~clk;

   grey_rx6_check #(
      .W     (W),
      .ERR_W (ERR_W)
   ) dut (
      .clk     (clk),
      .w_rst   (w_rst),
      .grey_in (grey_in),
      .clr_err (clr_err),
      .bin     (bin),
      .step    (step),
      .err     (err),
      .err_cnt (err_cnt),
      .locked  (locked),
      .stall   (stall)
   );

   typedef struct {
      logic [W-1:0]     grey;
      logic             clr;
      logic [W-1:0]     bin;
      logic             step;
      logic             err;
      logic [ERR_W-1:0] cnt;
      logic             locked;
   } vec_t;

   int           checks = 0;
   int           errors = 0;
   logic [W-1:0] prev_bin;
   vec_t         tbl[$];

`ifdef GREY_RX_STALL_EN
   localparam int unsigned FinalBin = 14;
`else
   localparam int unsigned FinalBin = 13;
`endif

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [W-1:0] g, input logic c, input logic [W-1:0] b,
                               input logic s, input logic e, input logic [ERR_W-1:0] n,
                               input logic l);
      vec_t v;
      v.grey = g; v.clr = c; v.bin = b; v.step = s; v.err = e; v.cnt = n; v.locked = l;
      return v;
   endfunction

   // New value lands in bin on the third edge after it is driven.
   task automatic apply(input vec_t v, input string tag);
      grey_in = v.grey;
      tick();
      tick();
      chk({tag, " bin_hold"}, bin, prev_bin);
      chk({tag, " step_early"}, step, 0);
      clr_err = v.clr;
      tick();
      clr_err = 1'b0;
      chk({tag, " bin"}, bin, v.bin);
      chk({tag, " step"}, step, v.step);
      chk({tag, " err"}, err, v.err);
      chk({tag, " err_cnt"}, err_cnt, v.cnt);
      chk({tag, " locked"}, locked, v.locked);
      chk({tag, " stall"}, stall, 0);
      prev_bin = v.bin;
      tick();
      chk({tag, " step_pulse"}, step, 0);
      chk({tag, " err_pulse"}, err, 0);
   endtask

   initial begin
      // Lock on 0..4
      tbl.push_back(mk(6'h01, 0, 1, 1, 0, 0, 0));
      tbl.push_back(mk(6'h03, 0, 2, 1, 0, 0, 0));
      tbl.push_back(mk(6'h02, 0, 3, 1, 0, 0, 0));
      tbl.push_back(mk(6'h06, 0, 4, 1, 0, 0, 1));
      // Jump 4 -> 8, relock
      tbl.push_back(mk(6'h0C, 0, 8, 0, 1, 1, 0));
      tbl.push_back(mk(6'h0D, 0, 9, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0F, 0, 10, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0E, 0, 11, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0A, 0, 12, 1, 0, 1, 1));
      // Jump to 59, relock at 63, then wrap to 0 while locked
      tbl.push_back(mk(6'h26, 0, 59, 0, 1, 2, 0));
      tbl.push_back(mk(6'h22, 0, 60, 1, 0, 2, 0));
      tbl.push_back(mk(6'h23, 0, 61, 1, 0, 2, 0));
      tbl.push_back(mk(6'h21, 0, 62, 1, 0, 2, 0));
      tbl.push_back(mk(6'h20, 0, 63, 1, 0, 2, 1));
      tbl.push_back(mk(6'h00, 0, 0, 1, 0, 2, 1));
      // Third error reaches saturation
      tbl.push_back(mk(6'h0C, 0, 8, 0, 1, 3, 0));
      tbl.push_back(mk(6'h0D, 0, 9, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0F, 0, 10, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0E, 0, 11, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0A, 0, 12, 1, 0, 3, 1));
      // Fourth and fifth errors hold at 3
      tbl.push_back(mk(6'h26, 0, 59, 0, 1, 3, 0));
      tbl.push_back(mk(6'h22, 0, 60, 1, 0, 3, 0));
      tbl.push_back(mk(6'h23, 0, 61, 1, 0, 3, 0));
      tbl.push_back(mk(6'h21, 0, 62, 1, 0, 3, 0));
      tbl.push_back(mk(6'h20, 0, 63, 1, 0, 3, 1));
      tbl.push_back(mk(6'h00, 0, 0, 1, 0, 3, 1));
      tbl.push_back(mk(6'h0C, 0, 8, 0, 1, 3, 0));
      tbl.push_back(mk(6'h0D, 0, 9, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0F, 0, 10, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0E, 0, 11, 1, 0, 3, 0));
      tbl.push_back(mk(6'h0A, 0, 12, 1, 0, 3, 1));
      // Sixth error with clr_err -> 1
      tbl.push_back(mk(6'h26, 1, 59, 0, 1, 1, 0));
      // Illegal change while LOCKING: no err, lock count restarts
      tbl.push_back(mk(6'h22, 0, 60, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0C, 0, 8, 0, 0, 1, 0));
      tbl.push_back(mk(6'h0D, 0, 9, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0F, 0, 10, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0E, 0, 11, 1, 0, 1, 0));
      tbl.push_back(mk(6'h0A, 0, 12, 1, 0, 1, 1));
      // Plain clear, no change
      tbl.push_back(mk(6'h0A, 1, 12, 0, 0, 0, 1));

      w_rst   = 1'b1;
      grey_in = '0;
      clr_err = 1'b0;
      tick();
      tick();
      chk("rst bin", bin, 0);
      chk("rst step", step, 0);
      chk("rst err", err, 0);
      chk("rst err_cnt", err_cnt, 0);
      chk("rst locked", locked, 0);
      chk("rst stall", stall, 0);
      w_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("idle%0d bin", i), bin, 0);
         chk($sformatf("idle%0d step", i), step, 0);
         chk($sformatf("idle%0d err", i), err, 0);
         chk($sformatf("idle%0d locked", i), locked, 0);
      end
      prev_bin = '0;

      foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

`ifdef GREY_RX_STALL_EN
      apply(mk(6'h0B, 0, 13, 1, 0, 0, 1), "stall_pre");
      repeat (62) tick();
      chk("stall_63", stall, 0);
      tick();
      chk("stall_64", stall, 1);
      chk("stall err", err, 0);
      chk("stall err_cnt", err_cnt, 0);
      chk("stall locked", locked, 1);
      apply(mk(6'h09, 0, 14, 1, 0, 0, 1), "stall_clr");
      repeat (63) tick();
      chk("stall_again", stall, 1);
`else
      apply(mk(6'h0B, 0, 13, 1, 0, 0, 1), "pre_rst");
`endif

      // Reset mid-operation while locked
      w_rst = 1'b1;
      tick();
      chk("mrst bin", bin, 0);
      chk("mrst step", step, 0);
      chk("mrst err", err, 0);
      chk("mrst err_cnt", err_cnt, 0);
      chk("mrst locked", locked, 0);
      chk("mrst stall", stall, 0);
      w_rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("flush%0d bin", i), bin, 0);
         chk($sformatf("flush%0d step", i), step, 0);
         chk($sformatf("flush%0d err", i), err, 0);
      end
      tick();
      chk("reload bin", bin, FinalBin);
      chk("reload step", step, 0);
      chk("reload err", err, 0);
      chk("reload locked", locked, 0);
      tick();
      chk("post step", step, 0);
      chk("post err", err, 0);
      chk("post locked", locked, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/grey_rx6_check.md
Name: grey_rx6_check

Overview:
- Downstream consumer of the 6-bit Grey counter driven by the divided-clock increment stage.
- Synchronises the incoming Grey bus, decodes it to binary and checks that every change is a legal single step (+1 mod 64).
- Flags illegal jumps, keeps a saturating error count, and reports lock status for the self-test / debug readout.

Parameters:
- W, 6, Grey/binary width. Legal range 2..8.
- SYNC_STAGES, 2, synchroniser flop depth on grey_in. Minimum 2.
- LOCK_STEPS, 4, consecutive legal steps required to enter LOCKED. Minimum 1.
- ERR_W, 8, width of err_cnt.
- STALL_CYCLES, 64, stall timeout in clk cycles. Used only with GREY_RX_STALL_EN.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- w_rst  input  1  reset: synchronous, active-high, clears all state.
- grey_in  input  W  Grey count from the upstream counter; may be asynchronous to clk.
- clr_err  input  1  synchronous clear of err_cnt.
- bin  output  W  registered binary decode of the synchronised Grey value.
- step  output  1  one-cycle pulse: bin advanced by exactly +1 mod 2^W.
- err  output  1  one-cycle pulse: illegal change detected while LOCKED.
- err_cnt  output  ERR_W  saturating count of err pulses.
- locked  output  1  high while the FSM is in LOCKED.
- stall  output  1  only with GREY_RX_STALL_EN: no step for STALL_CYCLES cycles while LOCKED.

Behaviour:
- Reset (w_rst=1 at an edge):
  - Sync flops, bin, step, err, err_cnt, locked, stall all 0.
  - FSM goes to FLUSH; all counters 0.
  - Reset asserted mid-operation behaves identically and aborts any state.
- Synchroniser: SYNC_STAGES flops on grey_in. d = Grey-to-binary of the last stage, where d[W-1]=g[W-1] and d[i]=d[i+1]^g[i].
- Compare/output timing: bin, step and err are registered together at the edge after d is valid. A stable grey_in change therefore reaches bin SYNC_STAGES+1 cycles after it is first sampled.
- Change classification: delta = d - bin, taken mod 2^W.
  - delta==0: no change; no pulse.
  - delta==1: legal step. This includes wrap from 2^W-1 to 0 (63->0 for W=6).
  - Any other delta: illegal.
- FSM states:
  - FLUSH: count SYNC_STAGES cycles without comparing, then load bin<=d. Go to LOCKING with lock_cnt=0.
  - LOCKING: bin<=d every cycle.
    - Legal step: lock_cnt+1; step pulses.
    - lock_cnt reaching LOCK_STEPS: go to LOCKED.
    - Illegal change: lock_cnt<=0. No err pulse; err_cnt is not incremented.
  - LOCKED: locked=1; bin<=d every cycle.
    - Legal step: step=1.
    - Illegal change: err=1; err_cnt+1, saturating at 2^ERR_W-1; go to LOCKING with lock_cnt=0. locked drops on the same edge.
- clr_err: err_cnt<=0 on the next edge.
  - If clr_err and an illegal change occur in the same cycle, err_cnt<=1.
  - At saturation, err_cnt holds; err still pulses.
- step and err are never high in the same cycle. Both are 0 whenever the FSM is in FLUSH.

Optional Feature:
- Macro: GREY_RX_STALL_EN.
- Defined:
  - A stall counter runs in LOCKED. It clears on every step and on leaving LOCKED.
  - When the counter reaches STALL_CYCLES, stall is set and stays high until the next step, exit from LOCKED, or w_rst.
  - stall does not affect err or err_cnt.
- Undefined:
  - stall is tied to 0 and no counter logic is built.
  - The port remains so the interface is identical either way.

Test Plan:
- Reset then hold grey_in=0 -> after SYNC_STAGES+1 cycles bin=0, locked=0, step/err never pulse.
- Grey sequence 0,1,3,2,6 (bin 0..4), one value every 4 clk, SYNC_STAGES=2 -> step pulses 4 times. locked rises with the 4th step, 3 cycles after the 4th value is applied.
- Once locked, sweep through wrap: Grey 0x20 (bin 63) -> 0x00 (bin 0) -> step=1, err=0, locked stays 1.
- Once locked, jump from Grey 0x06 (bin 4) to 0x0C (bin 8) -> err pulses once, err_cnt=1, locked=0. Four further legal steps -> locked=1.
- ERR_W=2, inject 5 illegal jumps, each followed by re-lock -> err_cnt saturates at 3. Assert clr_err together with a 6th jump -> err_cnt=1.
- GREY_RX_STALL_EN, STALL_CYCLES=64, locked then grey_in frozen -> stall=1 after 64 cycles. The next legal step clears stall.
- Also in the frozen case: assert w_rst mid-test -> all outputs 0 and the FSM restarts in FLUSH.
